// File: rtl/mps_intl_pkg.sv
// Shared constants for the analog interlock detector: default sizes and the
// "never trip" threshold reset window.
package mps_intl_pkg;

  localparam int N_CH_DEF = 18;
  localparam int DW_DEF   = 16;
  localparam int CH_W     = 5;

  localparam logic [DW_DEF-1:0] THR_HI_RST = 16'h7FFF;
  localparam logic [DW_DEF-1:0] THR_LO_RST = 16'h8000;

  // Widest window representable in a DW-bit two's-complement sample.
  function automatic logic [63:0] thr_hi_max(input int dw);
    thr_hi_max = (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] thr_lo_min(input int dw);
    thr_lo_min = 64'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/mps_intl_ch_debounce.sv
// One channel: threshold window, saturating out-of-window debounce counter and
// fault latch. Latch sets 1 clk after the tripping sample; no backpressure.
module mps_intl_ch_debounce
  import mps_intl_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = $clog2(DEBOUNCE + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_hit,
  input  logic signed [DW-1:0] i_data,
  input  logic                 i_thr_we,
  input  logic signed [DW-1:0] i_thr_hi,
  input  logic signed [DW-1:0] i_thr_lo,
  input  logic                 i_en,
  input  logic                 i_clr,
  output logic                 o_intl,
  output logic                 o_trip
);

  localparam logic [63:0]      HI_RST64 = thr_hi_max(DW);
  localparam logic [63:0]      LO_RST64 = thr_lo_min(DW);
  localparam logic [DW-1:0]    HI_RST   = HI_RST64[DW-1:0];
  localparam logic [DW-1:0]    LO_RST   = LO_RST64[DW-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic signed [DW-1:0] thr_hi_q, thr_hi_d;
  logic signed [DW-1:0] thr_lo_q, thr_lo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 intl_q, intl_d;
  logic                 out_win;
  logic                 trip;

  always_comb begin
    out_win  = (i_data > thr_hi_q) || (i_data < thr_lo_q);
    trip     = i_hit && out_win && (cnt_q == CNT_LAST);

    thr_hi_d = thr_hi_q;
    thr_lo_d = thr_lo_q;
    if (i_thr_we) begin
      thr_hi_d = i_thr_hi;
      thr_lo_d = i_thr_lo;
    end

    cnt_d = cnt_q;
    if (i_hit) begin
      if (!out_win) begin
        cnt_d = '0;
      end else if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // The sample above was judged on the old window; any zeroing source wins.
    if (i_thr_we || i_clr || !i_en) begin
      cnt_d = '0;
    end

    intl_d = trip | (intl_q & ~i_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      thr_hi_q <= HI_RST;
      thr_lo_q <= LO_RST;
      cnt_q    <= '0;
      intl_q   <= 1'b0;
    end else begin
      thr_hi_q <= thr_hi_d;
      thr_lo_q <= thr_lo_d;
      cnt_q    <= cnt_d;
      intl_q   <= intl_d;
    end
  end

  assign o_intl = intl_q;
  assign o_trip = trip;

endmodule

// File: rtl/mps_analog_intl_detect.sv
// Analog interlock vector: decodes the muxed ADC stream to per-channel debouncers,
// keeps the first-fault record and a registered OR. o_intl is 1 clk after the sample.
module mps_analog_intl_detect
  import mps_intl_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int DW       = DW_DEF,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = $clog2(DEBOUNCE + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_adc_valid,
  input  logic [CH_W-1:0] i_adc_ch,
  input  logic [DW-1:0]   i_adc_data,
  input  logic            i_thr_we,
  input  logic [CH_W-1:0] i_thr_sel,
  input  logic [DW-1:0]   i_thr_hi,
  input  logic [DW-1:0]   i_thr_lo,
  input  logic [N_CH-1:0] i_ch_en,
  input  logic            i_intl_clr,
  output logic [N_CH-1:0] o_intl,
  output logic            o_intl_any,
  output logic            o_first_valid,
  output logic [CH_W-1:0] o_first_ch
);

  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] thr_we;
  logic [N_CH-1:0] trip;
  logic [N_CH-1:0] intl;

  // Index equality against a per-channel constant also rejects ch >= N_CH.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign hit[g]    = i_adc_valid && (i_adc_ch == CH_W'(g)) && i_ch_en[g];
    assign thr_we[g] = i_thr_we && (i_thr_sel == CH_W'(g));

    mps_intl_ch_debounce #(
      .DW       (DW),
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_hit    (hit[g]),
      .i_data   (i_adc_data),
      .i_thr_we (thr_we[g]),
      .i_thr_hi (i_thr_hi),
      .i_thr_lo (i_thr_lo),
      .i_en     (i_ch_en[g]),
      .i_clr    (i_intl_clr),
      .o_intl   (intl[g]),
      .o_trip   (trip[g])
    );
  end

  logic            intl_any_q, intl_any_d;
  logic            first_valid_q, first_valid_d;
  logic [CH_W-1:0] first_ch_q, first_ch_d;
  logic [CH_W-1:0] trip_idx;

  always_comb begin
    trip_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (trip[i]) begin
        trip_idx = CH_W'(i);
      end
    end

    first_valid_d = first_valid_q;
    first_ch_d    = first_ch_q;
    if (i_intl_clr) begin
      first_valid_d = 1'b0;
    end
    // A trip coinciding with a clear becomes the new first fault.
    if ((|trip) && (!first_valid_q || i_intl_clr)) begin
      first_valid_d = 1'b1;
      first_ch_d    = trip_idx;
    end

    intl_any_d = |intl;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      intl_any_q    <= 1'b0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
    end else begin
      intl_any_q    <= intl_any_d;
      first_valid_q <= first_valid_d;
      first_ch_q    <= first_ch_d;
    end
  end

  assign o_intl        = intl;
  assign o_intl_any    = intl_any_q;
  assign o_first_valid = first_valid_q;
  assign o_first_ch    = first_ch_q;

endmodule
